// File: rtl/winner_judge.sv
// ---------------------------------------------------------------------------
// winner_judge
//
// Produces the winner_valid / winner_code verdict that lets the game state
// machine leave GAME. While a round is active it watches the collision and
// point pulses of the local and remote birds. If the second death lands
// within TIE_WINDOW cycles of the first, the round is a draw. The verdict is
// held until game_rst. The block also keeps a saturating score counter for
// each player, for the HUD.
//
// Optional feature (compile-time macro WINNER_JUDGE_SCORE_LIMIT_EN):
//   A point that takes a score to SCORE_LIMIT ends the round with that
//   player as the winner. A collision in the same cycle takes precedence.
//
// Parameters
//   TIE_WINDOW  : cycles after the first death in which the other player's
//                 death still counts as a draw (0 = no window)
//   SCORE_W     : width of each score counter
//   SCORE_LIMIT : outright winning score (only used with the macro defined)
//
// Ports
//   clk          : system clock
//   rst          : asynchronous, active-high reset
//   game_rst     : synchronous round clear (one-cycle pulse), top priority
//   game_active  : high while the game state machine is in GAME
//   local_hit    : local bird collision pulse
//   remote_hit   : remote bird collision pulse
//   local_point  : local bird passed a pipe
//   remote_point : remote bird passed a pipe
//   winner_valid : one-cycle verdict pulse
//   winner_code  : 00 none, 01 local wins, 10 remote wins, 11 draw
//   local_score  : local saturating score
//   remote_score : remote saturating score
//   pending      : high while the tie window is open
// ---------------------------------------------------------------------------
module winner_judge #(
    parameter int TIE_WINDOW  = 8,
    parameter int SCORE_W     = 8,
    parameter int SCORE_LIMIT = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_rst,
    input  logic               game_active,
    input  logic               local_hit,
    input  logic               remote_hit,
    input  logic               local_point,
    input  logic               remote_point,
    output logic               winner_valid,
    output logic [1:0]         winner_code,
    output logic [SCORE_W-1:0] local_score,
    output logic [SCORE_W-1:0] remote_score,
    output logic               pending
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PEND_L = 3'd2,
        S_PEND_R = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int CNT_W = (TIE_WINDOW > 0) ? $clog2(TIE_WINDOW + 1) : 1;
    localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(TIE_WINDOW);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] LIMIT_VAL = SCORE_W'(SCORE_LIMIT);

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_LOCAL  = 2'b01;
    localparam logic [1:0] CODE_REMOTE = 2'b10;
    localparam logic [1:0] CODE_DRAW   = 2'b11;

`ifdef WINNER_JUDGE_SCORE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         verdict_q, verdict_d;
    logic               winner_valid_q, winner_valid_d;
    logic [1:0]         winner_code_q, winner_code_d;
    logic               pending_q, pending_d;
    logic [SCORE_W-1:0] local_score_q, local_score_d;
    logic [SCORE_W-1:0] remote_score_q, remote_score_d;

    logic [SCORE_W-1:0] local_inc_s;
    logic [SCORE_W-1:0] remote_inc_s;
    logic               local_lim_s;
    logic               remote_lim_s;

    // Saturating increment: holds at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] val);
        if (val == SCORE_MAX) begin
            sat_inc = val;
        end else begin
            sat_inc = val + SCORE_W'(1);
        end
    endfunction

    // Next-state, verdict and score computation.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        verdict_d      = verdict_q;
        winner_valid_d = 1'b0;
        winner_code_d  = winner_code_q;
        local_score_d  = local_score_q;
        remote_score_d = remote_score_q;

        local_inc_s  = sat_inc(local_score_q);
        remote_inc_s = sat_inc(remote_score_q);
        // A limit is reached only when the point actually changes the score.
        local_lim_s  = LIMIT_EN && local_point &&
                       (local_score_q != LIMIT_VAL) && (local_inc_s == LIMIT_VAL);
        remote_lim_s = LIMIT_EN && remote_point &&
                       (remote_score_q != LIMIT_VAL) && (remote_inc_s == LIMIT_VAL);

        if (game_rst) begin
            state_d        = S_IDLE;
            cnt_d          = '0;
            verdict_d      = CODE_NONE;
            winner_code_d  = CODE_NONE;
            local_score_d  = '0;
            remote_score_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (game_active) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (local_point) begin
                        local_score_d = local_inc_s;
                    end else begin
                        local_score_d = local_score_q;
                    end
                    if (remote_point) begin
                        remote_score_d = remote_inc_s;
                    end else begin
                        remote_score_d = remote_score_q;
                    end
                    // A dead bird means the other player wins, so local_hit maps to 10.
                    if (local_hit && remote_hit) begin
                        state_d   = S_REPORT;
                        verdict_d = CODE_DRAW;
                    end else if (local_hit) begin
                        if (TIE_WINDOW == 0) begin
                            state_d   = S_REPORT;
                            verdict_d = CODE_REMOTE;
                        end else begin
                            state_d = S_PEND_L;
                            cnt_d   = CNT_INIT;
                        end
                    end else if (remote_hit) begin
                        if (TIE_WINDOW == 0) begin
                            state_d   = S_REPORT;
                            verdict_d = CODE_LOCAL;
                        end else begin
                            state_d = S_PEND_R;
                            cnt_d   = CNT_INIT;
                        end
                    end else if (local_lim_s || remote_lim_s) begin
                        state_d   = S_REPORT;
                        verdict_d = {remote_lim_s, local_lim_s};
                    end else if (!game_active) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_PEND_L: begin
                    // The count at the last window edge is 1, so expiry is detected there.
                    if (remote_hit) begin
                        state_d   = S_REPORT;
                        verdict_d = CODE_DRAW;
                        cnt_d     = '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d   = S_REPORT;
                        verdict_d = CODE_REMOTE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_PEND_R: begin
                    if (local_hit) begin
                        state_d   = S_REPORT;
                        verdict_d = CODE_DRAW;
                        cnt_d     = '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d   = S_REPORT;
                        verdict_d = CODE_LOCAL;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    winner_valid_d = 1'b1;
                    winner_code_d  = verdict_q;
                    state_d        = S_DONE;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        pending_d = (state_d == S_PEND_L) || (state_d == S_PEND_R);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            verdict_q      <= CODE_NONE;
            winner_valid_q <= 1'b0;
            winner_code_q  <= CODE_NONE;
            pending_q      <= 1'b0;
            local_score_q  <= '0;
            remote_score_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            verdict_q      <= verdict_d;
            winner_valid_q <= winner_valid_d;
            winner_code_q  <= winner_code_d;
            pending_q      <= pending_d;
            local_score_q  <= local_score_d;
            remote_score_q <= remote_score_d;
        end
    end

    assign winner_valid = winner_valid_q;
    assign winner_code  = winner_code_q;
    assign pending      = pending_q;
    assign local_score  = local_score_q;
    assign remote_score = remote_score_q;

endmodule
